vga_sync_out: RTL and testbench

- Timing master and output stage for the VGA display path.
- Generates the pixel tick and the pixel coordinates (pix_x, pix_y) that the pixel-generator blocks consume (graph, text).
- Takes back their colour result and drives registered hsync/vsync/rgb to the pins, with sync aligned to colour.
- Also produces the once-per-frame refresh tick that game logic uses for motion updates.

---
 rtl/vga_sync_out.sv | 101 ++++++++++
 tb/tb_vga_sync_out.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_out.sv
// VGA timing master and pin-side output stage: pixel tick, pixel coordinates, frame tick,
// and registered hsync/vsync/rgb aligned so that sync and colour for a pixel leave together.
module vga_sync_out #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned CLK_DIV     = 2,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       frame_tick,
    input  logic [2:0] rgb_in,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [2:0] vga_rgb
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_last;
    logic             v_last;
    logic             hs_raw;
    logic             vs_raw;

    // With CLK_DIV=1 the divider is a constant-zero register and p_tick stays high.
    assign p_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (p_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (p_tick) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign pix_x      = h_cnt;
    assign pix_y      = v_cnt;
    assign video_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign frame_tick = p_tick && h_last && (v_cnt == V_VIS);

    assign hs_raw = ((h_cnt >= HS_START) && (h_cnt <= HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vs_raw = ((v_cnt >= VS_START) && (v_cnt <= VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

    // One pixel of latency; sync goes through the same register stage as colour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_rgb   <= 3'b000;
            vga_hsync <= ~SYNC_ACTIVE;
            vga_vsync <= ~SYNC_ACTIVE;
        end else if (p_tick) begin
            vga_rgb   <= video_on ? rgb_in : 3'b000;
            vga_hsync <= hs_raw;
            vga_vsync <= vs_raw;
        end
    end

endmodule

// File: tb/tb_vga_sync_out.sv
// Bench for vga_sync_out: three builds (default timing, small timing with CLK_DIV 3 and 1),
// each compared every clock against a pixel-count model, plus hand-computed timing checks.
module tb_vga_sync_out;

    logic clk;
    logic reset;
    int   mode;
    int   checks;
    int   failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input int g, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[dut%0d]: got %0d expected %0d", name, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int HD = (g == 0) ? 640 : 8;
        localparam int HF = (g == 0) ? 16 : 2;
        localparam int HS = (g == 0) ? 96 : 3;
        localparam int HB = (g == 0) ? 48 : 2;
        localparam int VD = (g == 0) ? 480 : 6;
        localparam int VF = (g == 0) ? 10 : 1;
        localparam int VS = 2;
        localparam int VB = (g == 0) ? 33 : 2;
        localparam int D  = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
        localparam logic SA = (g == 2);
        localparam int HT = HD + HF + HS + HB;
        localparam int VT = VD + VF + VS + VB;

        logic       p_tick;
        logic       video_on;
        logic       frame_tick;
        logic       vga_hsync;
        logic       vga_vsync;
        logic [9:0] pix_x;
        logic [9:0] pix_y;
        logic [2:0] rgb_in;
        logic [2:0] vga_rgb;
        logic [2:0] last_rgb;
        int         k;

        vga_sync_out #(
            .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
            .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
            .CLK_DIV(D), .SYNC_ACTIVE(SA)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .p_tick    (p_tick),
            .pix_x     (pix_x),
            .pix_y     (pix_y),
            .video_on  (video_on),
            .frame_tick(frame_tick),
            .rgb_in    (rgb_in),
            .vga_hsync (vga_hsync),
            .vga_vsync (vga_vsync),
            .vga_rgb   (vga_rgb)
        );

        // Model: k clocks since reset, k/D pixels consumed, colour captured at each consumption.
        always @(posedge clk or posedge reset) begin
            if (reset) begin
                k <= 0;
            end else begin
                if (k % D == D - 1) last_rgb <= rgb_in;
                k <= k + 1;
            end
        end

        initial begin
            int t, u, ux, uy, ex, ey, ept, evid, eft, ehs, evs, ergb;
            rgb_in = 3'b000;
            forever begin
                @(negedge clk);
                t   = k / D;
                ept = int'(k % D == D - 1);
                ex  = t % HT;
                ey  = (t / HT) % VT;
                if (!reset) begin
                    evid = int'(ex < HD && ey < VD);
                    eft  = int'(ept == 1 && ex == HT - 1 && ey == VD);
                    if (t == 0) begin
                        ehs  = int'(!SA);
                        evs  = int'(!SA);
                        ergb = 0;
                    end else begin
                        u    = t - 1;
                        ux   = u % HT;
                        uy   = (u / HT) % VT;
                        ehs  = (ux >= HD + HF && ux < HD + HF + HS) ? int'(SA) : int'(!SA);
                        evs  = (uy >= VD + VF && uy < VD + VF + VS) ? int'(SA) : int'(!SA);
                        ergb = (ux < HD && uy < VD) ? int'(last_rgb) : 0;
                    end
                    check(g, "p_tick", int'(p_tick), ept);
                    check(g, "pix_x", int'(pix_x), ex);
                    check(g, "pix_y", int'(pix_y), ey);
                    check(g, "video_on", int'(video_on), evid);
                    check(g, "frame_tick", int'(frame_tick), eft);
                    check(g, "vga_hsync", int'(vga_hsync), ehs);
                    check(g, "vga_vsync", int'(vga_vsync), evs);
                    check(g, "vga_rgb", int'(vga_rgb), ergb);
                end
                case (mode)
                    0:       rgb_in = 3'($urandom);
                    1:       rgb_in = (ex == 0 && ey == 0) ? 3'b101 : 3'b000;
                    default: rgb_in = 3'b111;
                endcase
            end
        end
    end

    initial begin
        int n, c0, c1;
        checks   = 0;
        failures = 0;
        mode     = 0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        check(0, "rst0_pix_x", int'(g_dut[0].pix_x), 0);
        check(0, "rst0_hsync", int'(g_dut[0].vga_hsync), 1);
        check(0, "rst0_rgb", int'(g_dut[0].vga_rgb), 0);
        check(0, "rst0_p_tick", int'(g_dut[0].p_tick), 0);
        reset = 1'b0;
        @(negedge clk);
        check(0, "first_tick", int'(g_dut[0].p_tick), 1);
        check(0, "first_tick_x", int'(g_dut[0].pix_x), 0);
        @(negedge clk);
        check(0, "after_tick_x", int'(g_dut[0].pix_x), 1);
        check(0, "after_tick_p", int'(g_dut[0].p_tick), 0);

        // Reset in the middle of the hsync pulse.
        n = 0;
        while (g_dut[0].pix_x != 10'd700 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(0, "reach_x700", int'(g_dut[0].pix_x), 700);
        check(0, "hs_before_rst", int'(g_dut[0].vga_hsync), 0);
        #2 reset = 1'b1;
        #1;
        check(0, "rst_pix_x", int'(g_dut[0].pix_x), 0);
        check(0, "rst_pix_y", int'(g_dut[0].pix_y), 0);
        check(0, "rst_hsync", int'(g_dut[0].vga_hsync), 1);
        check(0, "rst_vsync", int'(g_dut[0].vga_vsync), 1);
        check(0, "rst_rgb", int'(g_dut[0].vga_rgb), 0);
        check(0, "rst_frame", int'(g_dut[0].frame_tick), 0);
        check(0, "rst_p_tick", int'(g_dut[0].p_tick), 0);
        check(2, "rst_hsync_hi_active", int'(g_dut[2].vga_hsync), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Horizontal sync placement, width and line period on the default build.
        n = 0;
        while (g_dut[0].vga_hsync != 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(0, "hs_fall_x", int'(g_dut[0].pix_x), 657);
        check(0, "hs_fall_y", int'(g_dut[0].pix_y), 0);
        n = 0;
        while (g_dut[0].vga_hsync == 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(0, "hs_low_clks", n, 192);
        while (g_dut[0].vga_hsync != 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(0, "line_clks", n, 1600);

        // Frame period on the small builds.
        for (int g = 1; g < 3; g++) begin
            n = 0;
            while (((g == 1) ? g_dut[1].frame_tick : g_dut[2].frame_tick) != 1'b1 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            n = 0;
            @(negedge clk);
            n++;
            while (((g == 1) ? g_dut[1].frame_tick : g_dut[2].frame_tick) != 1'b1 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check(g, "frame_period", n, (g == 1) ? 495 : 165);
        end

        c0 = 0;
        c1 = 0;
        repeat (495) begin
            @(negedge clk);
            if (g_dut[1].vga_vsync == 1'b0) c0++;
            if (g_dut[2].p_tick == 1'b1) c1++;
        end
        check(1, "vs_low_clks", c0, 90);
        check(2, "p_tick_always", c1, 495);

        // Single coloured pixel at (0,0).
        mode = 1;
        repeat (500) @(negedge clk);
        c0 = 0;
        repeat (495) begin
            @(negedge clk);
            if (g_dut[1].vga_rgb == 3'b101) c0++;
        end
        check(1, "rgb101_clks", c0, 3);

        // Constant white input: colour only over the visible area.
        mode = 2;
        repeat (500) @(negedge clk);
        c0 = 0;
        c1 = 0;
        n  = 0;
        repeat (495) begin
            @(negedge clk);
            if (g_dut[1].vga_rgb == 3'b111) c0++;
            if (g_dut[1].vga_rgb == 3'b000) c1++;
            if (g_dut[2].vga_rgb == 3'b111) n++;
        end
        check(1, "white_clks", c0, 144);
        check(1, "black_clks", c1, 351);
        check(2, "white_clks", n, 144);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
